data_memory_controller: RTL and testbench
=========================================

Name: data_memory_controller

Overview:
- Initiator side of the data-memory port: accepts load/store requests from the core over a valid/ready handshake and drives address/data_in/write into the 128-byte data memory.
- Splits 16-bit accesses into two byte accesses, little-endian.
- Compensates for the memory's one-cycle registered read.
- Flags out-of-range accesses itself and never issues them to the memory.

Parameters:
- ADDR_WIDTH, 8, width of byte address on both core and memory sides.
- MEM_LAST, 127, highest valid byte address in data memory.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_wide  in  1  1 = 16-bit access, 0 = 8-bit
- req_addr  in  ADDR_WIDTH  byte address (low byte for wide)
- req_wdata  in  16  store data; only [7:0] used when narrow
- resp_valid  out  1  response available
- resp_ready  in  1  core accepts response
- resp_rdata  out  16  load data; narrow loads zero-extended; 16'h0000 for stores/faults
- resp_fault  out  1  access was out of range, not performed
- mem_address  out  ADDR_WIDTH  to memory address
- mem_data_in  out  8  to memory data_in
- mem_write  out  1  to memory write
- mem_data_out  in  8  from memory data_out (valid the cycle after a read issue)

Behaviour:
- Reset (async, reset=0): state IDLE. req_ready=0 while in reset, 1 after. resp_valid=0, resp_rdata=0, resp_fault=0, mem_address=0, mem_data_in=0, mem_write=0.
- Reset mid-operation aborts immediately. A wide store interrupted after its low byte leaves that byte written; there is no rollback.
- States: IDLE, ISSUE_LO, ISSUE_HI, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch write, wide, addr and wdata.
  - Range check: fault if addr>MEM_LAST, or if wide and addr+1>MEM_LAST. The check is computed in ADDR_WIDTH+1 bits, so addr 255 wide does not wrap.
  - Fault goes to RESP with resp_fault=1. Otherwise go to ISSUE_LO.
- ISSUE_LO:
  - mem_address=addr, mem_write=write, mem_data_in=wdata[7:0].
  - Next state: wide goes to ISSUE_HI; narrow load goes to CAPTURE; narrow store goes to RESP.
- ISSUE_HI:
  - mem_address=addr+1, mem_write=write, mem_data_in=wdata[15:8].
  - For a load, resp_rdata[7:0] is sampled from mem_data_out at the end of this cycle (the low byte issued in ISSUE_LO).
  - Next state: load goes to CAPTURE; store goes to RESP.
- CAPTURE:
  - mem_write=0.
  - Sample mem_data_out into resp_rdata[15:8] if wide, or into [7:0] (upper byte 0) if narrow.
  - Next state: RESP.
- RESP:
  - resp_valid=1. resp_rdata and resp_fault are stable.
  - Hold until resp_ready=1, then go to IDLE with resp_valid=0 and resp_fault=0 on that edge.
- Outside ISSUE states: mem_write=0. mem_address and mem_data_in hold their last values, so the memory's idle reads are harmless and their results are ignored.
- Stall: req_ready=0 in every state except IDLE. There are no back-to-back accepts and no request overlaps a response.
- Latency, counted as edges from the accepting edge to resp_valid high (with resp_ready held high):
  - fault: 1
  - narrow store: 2
  - wide store: 3
  - narrow load: 3
  - wide load: 4
- Once accepted, the request is fully latched. Changes on req_* during an operation have no effect.
- Store responses: resp_rdata=16'h0000.

Decomposition:
- Shared package holds:
  - state enum encoding (IDLE=0 … RESP=4);
  - MEM_LAST and ADDR_WIDTH defaults;
  - RESP_DATA_ZERO constant.
- One natural sub-module: dmem_range_check, combinational. Inputs addr and wide; output fault. It is reused later by the instruction-fetch side.
- Rest is a single FSM plus datapath registers.

Test Plan:
- Narrow store addr=8'h10, wdata=16'h00A5 then narrow load addr=8'h10 -> mem_write=1 for exactly one cycle with mem_address=8'h10 and mem_data_in=8'hA5; load resp_rdata=16'h00A5, resp_fault=0, resp_valid 3 edges after accept.
- Wide store addr=8'h20, wdata=16'hBEEF then wide load addr=8'h20 -> memory writes 8'hEF@8'h20 and 8'hBE@8'h21 in consecutive cycles; load resp_rdata=16'hBEEF after 4 edges.
- Wide load addr=8'h7F -> resp_fault=1, resp_rdata=0, after 1 edge; mem_write stays 0 and mem_address is unchanged. Narrow load addr=8'h80 gives the same result.
- Response backpressure: resp_ready=0 for 5 cycles during a load of 8'h33 -> resp_valid and resp_rdata held stable, req_ready=0 throughout; one cycle after resp_ready=1, req_ready=1.
- reset driven low during ISSUE_HI of a wide store to 8'h40 -> all outputs 0 asynchronously (before the next edge); after release, the narrow load at 8'h40 returns the low byte written and the load at 8'h41 returns its prior contents.
- req_valid held high with changing req_addr during a wide load -> exactly one transaction, using the address latched at accept.

Source files
------------

// File: rtl/data_memory_controller_pkg.sv
// Shared definitions for the data-memory controller and its range checker.
// Holds the FSM state encoding, default geometry of the data memory and the
// response value returned for stores and faulted accesses.
package data_memory_controller_pkg;

  localparam int DMC_ADDR_WIDTH = 8;
  localparam int DMC_MEM_LAST   = 127;

  localparam logic [15:0] RESP_DATA_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_LO = 3'd1,
    ST_ISSUE_HI = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_RESP     = 3'd4
  } dmc_state_t;

endpackage

// File: rtl/dmem_range_check.sv
// Combinational range check for data-memory accesses.
// Ports:
//   addr  - byte address (low byte of a wide access)
//   wide  - 1 = 16-bit access touching addr and addr+1
//   fault - access reaches beyond MEM_LAST
module dmem_range_check
  import data_memory_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DMC_ADDR_WIDTH,
  parameter int MEM_LAST   = DMC_MEM_LAST
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wide,
  output logic                  fault
);

  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(MEM_LAST);

  logic [ADDR_WIDTH:0] w_top;

  // One extra bit so that the highest address plus one does not wrap to 0.
  always_comb begin
    w_top = {1'b0, addr} + {{ADDR_WIDTH{1'b0}}, wide};
    fault = (w_top > LAST);
  end

endmodule

// File: rtl/data_memory_controller.sv
// Initiator side of the data-memory port. Accepts load/store requests from
// the core, splits 16-bit accesses into two little-endian byte accesses,
// compensates for the memory's registered read and rejects out-of-range
// accesses without touching the memory.
// Ports:
//   clock, reset               - clock, async active-low reset
//   req_*                      - core request channel (valid/ready)
//   resp_*                     - core response channel (valid/ready)
//   mem_address/data_in/write  - to the 128-byte data memory
//   mem_data_out               - memory read data, valid one cycle after issue
module data_memory_controller
  import data_memory_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DMC_ADDR_WIDTH,
  parameter int MEM_LAST   = DMC_MEM_LAST
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_wide,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [15:0]           resp_rdata,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write,
  input  logic [7:0]            mem_data_out
);

  dmc_state_t            r_state, w_next;
  logic                  r_write, r_wide;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_wdata;
  logic [15:0]           r_rdata;
  logic                  r_fault;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [7:0]            r_mem_data_in;
  logic                  w_fault;
  logic                  w_accept;

  dmem_range_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_LAST   (MEM_LAST)
  ) u_range_check (
    .addr  (req_addr),
    .wide  (req_wide),
    .fault (w_fault)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    w_accept   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Gated by reset so ready reads 0 while reset is held.
        req_ready = reset;
        w_accept  = req_valid;
        if (req_valid) w_next = w_fault ? ST_RESP : ST_ISSUE_LO;
      end
      ST_ISSUE_LO: begin
        mem_write = r_write;
        if (r_wide)       w_next = ST_ISSUE_HI;
        else if (r_write) w_next = ST_RESP;
        else              w_next = ST_CAPTURE;
      end
      ST_ISSUE_HI: begin
        mem_write = r_write;
        w_next    = r_write ? ST_RESP : ST_CAPTURE;
      end
      ST_CAPTURE: w_next = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The memory-side address/data are registered and loaded one state ahead,
  // so they are already stable for the whole issue cycle and simply hold
  // their last value once the access is done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write       <= 1'b0;
      r_wide        <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= RESP_DATA_ZERO;
      r_fault       <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_wide  <= req_wide;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rdata <= RESP_DATA_ZERO;
        r_fault <= w_fault;
        if (!w_fault) begin
          r_mem_address <= req_addr;
          r_mem_data_in <= req_wdata[7:0];
        end
      end
      if (r_state == ST_ISSUE_LO && r_wide) begin
        r_mem_address <= r_addr + ADDR_WIDTH'(1);
        r_mem_data_in <= r_wdata[15:8];
      end
      // Memory read data lags the issue by one cycle.
      if (r_state == ST_ISSUE_HI && !r_write) r_rdata[7:0] <= mem_data_out;
      if (r_state == ST_CAPTURE) begin
        if (r_wide) r_rdata[15:8] <= mem_data_out;
        else        r_rdata       <= {8'h00, mem_data_out};
      end
      if (r_state == ST_RESP && resp_ready) r_fault <= 1'b0;
    end
  end

  assign resp_rdata  = r_rdata;
  assign resp_fault  = r_fault;
  assign mem_address = r_mem_address;
  assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_data_memory_controller.sv
module tb_data_memory_controller;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_wide;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_fault;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data_in;
  logic        mem_write;
  logic [7:0]  mem_data_out;

  int tests_run;
  int tests_failed;

  data_memory_controller #(
    .ADDR_WIDTH (8),
    .MEM_LAST   (127)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_wide     (req_wide),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural 128-byte memory with registered read, plus a write log.
  logic [7:0] mem [0:127];
  logic [7:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         wr_cyc  [$];
  int         cyc;
  int         accepts;
  int         bad_issue;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[8'h33] = 8'h3C;
    mem[8'h41] = 8'h5C;
    mem[8'h7E] = 8'h11;
    mem[8'h7F] = 8'h22;
    mem_data_out = 8'h00;
    cyc = 0;
    accepts = 0;
    bad_issue = 0;
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) accepts <= accepts + 1;
    if (mem_write) begin
      if (mem_address > 8'd127) bad_issue <= bad_issue + 1;
      mem[mem_address[6:0]] <= mem_data_in;
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_data_in);
      wr_cyc.push_back(cyc);
    end
    mem_data_out <= mem[mem_address[6:0]];
  end

  // Drives one request starting in IDLE (#1 after an edge), returns the
  // accept-to-resp_valid latency, then exits RESP with resp_ready high.
  task automatic do_req(input logic w, input logic wd, input logic [7:0] a,
                        input logic [15:0] d, output int lat,
                        output logic [15:0] rd, output logic f);
    req_write = w; req_wide = wd; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!resp_valid) lat = 99;
    rd = resp_rdata;
    f  = resp_fault;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
    req_addr = 8'h00; req_wdata = 16'h0000; resp_ready = 1'b1;
    #12;
    tests_run++;
    if ({req_ready, resp_valid, resp_fault, mem_write} !== 4'b0000 ||
        resp_rdata !== 16'h0000 || mem_address !== 8'h00 || mem_data_in !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: rdy=%b rv=%b rf=%b mw=%b rd=%h ma=%h md=%h, required all 0",
               req_ready, resp_valid, resp_fault, mem_write, resp_rdata, mem_address, mem_data_in);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_reset: got %b required 1", req_ready);
    end
  endtask

  task automatic test_narrow();
    int lat; logic [15:0] rd; logic f; int n0;
    n0 = wr_addr.size();
    do_req(1'b1, 1'b0, 8'h10, 16'h00A5, lat, rd, f);
    tests_run++;
    if (wr_addr.size() - n0 != 1 || wr_addr[n0] !== 8'h10 || wr_data[n0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL narrow_store_write: %0d writes, first %h@%h, required 1 write A5@10",
               wr_addr.size() - n0, (wr_addr.size() > n0) ? wr_data[n0] : 8'hxx,
               (wr_addr.size() > n0) ? wr_addr[n0] : 8'hxx);
    end
    tests_run++;
    if (lat != 2 || rd !== 16'h0000 || f !== 1'b0) begin
      tests_failed++;
      $display("FAIL narrow_store_resp: lat=%0d rd=%h f=%b, required lat=2 rd=0000 f=0", lat, rd, f);
    end
    do_req(1'b0, 1'b0, 8'h10, 16'hFFFF, lat, rd, f);
    tests_run++;
    if (lat != 3 || rd !== 16'h00A5 || f !== 1'b0) begin
      tests_failed++;
      $display("FAIL narrow_load: lat=%0d rd=%h f=%b, required lat=3 rd=00A5 f=0", lat, rd, f);
    end
  endtask

  task automatic test_wide();
    int lat; logic [15:0] rd; logic f; int n0;
    n0 = wr_addr.size();
    do_req(1'b1, 1'b1, 8'h20, 16'hBEEF, lat, rd, f);
    tests_run++;
    if (wr_addr.size() - n0 != 2 || wr_addr[n0] !== 8'h20 || wr_data[n0] !== 8'hEF ||
        wr_addr[n0+1] !== 8'h21 || wr_data[n0+1] !== 8'hBE || wr_cyc[n0+1] - wr_cyc[n0] != 1) begin
      tests_failed++;
      $display("FAIL wide_store_write: %0d writes, required EF@20 then BE@21 in consecutive cycles",
               wr_addr.size() - n0);
    end
    tests_run++;
    if (lat != 3 || rd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wide_store_resp: lat=%0d rd=%h, required lat=3 rd=0000", lat, rd);
    end
    do_req(1'b0, 1'b1, 8'h20, 16'h0000, lat, rd, f);
    tests_run++;
    if (lat != 4 || rd !== 16'hBEEF || f !== 1'b0) begin
      tests_failed++;
      $display("FAIL wide_load: lat=%0d rd=%h f=%b, required lat=4 rd=BEEF f=0", lat, rd, f);
    end
    do_req(1'b0, 1'b1, 8'h7E, 16'h0000, lat, rd, f);
    tests_run++;
    if (lat != 4 || rd !== 16'h2211 || f !== 1'b0) begin
      tests_failed++;
      $display("FAIL wide_load_top: lat=%0d rd=%h f=%b, required lat=4 rd=2211 f=0", lat, rd, f);
    end
    do_req(1'b0, 1'b0, 8'h7F, 16'h0000, lat, rd, f);
    tests_run++;
    if (lat != 3 || rd !== 16'h0022 || f !== 1'b0) begin
      tests_failed++;
      $display("FAIL narrow_load_top: lat=%0d rd=%h f=%b, required lat=3 rd=0022 f=0", lat, rd, f);
    end
  endtask

  task automatic test_fault();
    int lat; logic [15:0] rd; logic f; int n0; logic [7:0] ma0;
    logic [7:0] addrs [3];
    logic       wides [3];
    addrs[0] = 8'h7F; wides[0] = 1'b1;
    addrs[1] = 8'h80; wides[1] = 1'b0;
    addrs[2] = 8'hFF; wides[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n0 = wr_addr.size();
      ma0 = mem_address;
      do_req(1'b0, wides[i], addrs[i], 16'h0000, lat, rd, f);
      tests_run++;
      if (lat != 1 || f !== 1'b1 || rd !== 16'h0000 || wr_addr.size() != n0 ||
          mem_address !== ma0 || bad_issue != 0) begin
        tests_failed++;
        $display("FAIL fault_%h_w%b: lat=%0d f=%b rd=%h ma=%h(was %h) writes=%0d, required lat=1 f=1 rd=0000 ma unchanged",
                 addrs[i], wides[i], lat, f, rd, mem_address, ma0, wr_addr.size() - n0);
      end
    end
    tests_run++;
    if (resp_fault !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_clear: rf=%b rv=%b, required 0 0", resp_fault, resp_valid);
    end
  endtask

  task automatic test_backpressure();
    int n; logic ok;
    resp_ready = 1'b0;
    req_write = 1'b0; req_wide = 1'b0; req_addr = 8'h33; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clock); #1; n++; end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== 16'h003C || req_ready !== 1'b0) ok = 1'b0;
      @(posedge clock); #1;
    end
    tests_run++;
    if (!ok || resp_valid !== 1'b1 || resp_rdata !== 16'h003C) begin
      tests_failed++;
      $display("FAIL backpressure_hold: rv=%b rd=%h rdy=%b, required rv=1 rd=003C rdy=0 held",
               resp_valid, resp_rdata, req_ready);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: rdy=%b rv=%b, required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [15:0] rd; logic f;
    req_write = 1'b1; req_wide = 1'b1; req_addr = 8'h40; req_wdata = 16'h1234; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if (mem_write !== 1'b1 || mem_address !== 8'h41 || mem_data_in !== 8'h12) begin
      tests_failed++;
      $display("FAIL issue_hi: mw=%b ma=%h md=%h, required 1 41 12", mem_write, mem_address, mem_data_in);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, resp_valid, resp_fault, mem_write} !== 4'b0000 ||
        resp_rdata !== 16'h0000 || mem_address !== 8'h00 || mem_data_in !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_reset: rdy=%b rv=%b rf=%b mw=%b rd=%h ma=%h md=%h, required all 0",
               req_ready, resp_valid, resp_fault, mem_write, resp_rdata, mem_address, mem_data_in);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    do_req(1'b0, 1'b0, 8'h40, 16'h0000, lat, rd, f);
    tests_run++;
    if (rd !== 16'h0034 || lat != 3) begin
      tests_failed++;
      $display("FAIL reset_low_byte: rd=%h lat=%0d, required 0034 lat=3", rd, lat);
    end
    do_req(1'b0, 1'b0, 8'h41, 16'h0000, lat, rd, f);
    tests_run++;
    if (rd !== 16'h005C) begin
      tests_failed++;
      $display("FAIL reset_high_byte: rd=%h, required 005C", rd);
    end
  endtask

  task automatic test_held_valid();
    int a0; logic ok;
    a0 = accepts;
    ok = 1'b1;
    req_write = 1'b0; req_wide = 1'b1; req_addr = 8'h20; req_valid = 1'b1;
    @(posedge clock); #1;
    if (mem_address !== 8'h20) ok = 1'b0;
    req_addr = 8'h50;
    @(posedge clock); #1;
    if (mem_address !== 8'h21) ok = 1'b0;
    req_addr = 8'h60;
    @(posedge clock); #1;
    req_addr = 8'h70;
    @(posedge clock); #1;
    tests_run++;
    if (!ok || resp_valid !== 1'b1 || resp_rdata !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL held_valid_data: addr_ok=%b rv=%b rd=%h, required 1 1 BEEF", ok, resp_valid, resp_rdata);
    end
    req_valid = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if (accepts - a0 != 1) begin
      tests_failed++;
      $display("FAIL held_valid_accepts: got %0d required 1", accepts - a0);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_narrow();
    test_wide();
    test_fault();
    test_backpressure();
    test_reset_mid_op();
    test_held_valid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
